parity_stream_pipe: RTL and testbench

// - Parametrised, registered parity generator/checker for a valid/ready data stream.
// - Per accepted beat: computes parity over DATA_W bits, optionally checks the received parity bit,
//   and forwards data, parity and error through one pipeline stage.
// - Sits between a link receiver and downstream logic. Keeps a sticky error flag and an optional error counter.

---
 rtl/parity_stream_if.sv | 29 ++
 rtl/parity_stream_pipe.sv | 106 ++++++++++
 tb/tb_parity_stream_pipe.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/parity_stream_if.sv
// Stream bundle for parity_stream_pipe: the input beat (with its parity and check
// enable), the registered output beat, and both ready signals.
interface parity_stream_if #(
    parameter int DATA_W = 8
);
    // A beat transfers on a rising clock edge where valid && ready. Once valid is
    // raised, the producer holds valid and the payload stable until that edge.
    // A producer never waits for ready before raising valid.
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_parity;
    logic              chk_en;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_parity;
    logic              out_err;

    modport slave (
        input  in_valid, in_data, in_parity, chk_en, out_ready,
        output in_ready, out_valid, out_data, out_parity, out_err
    );

    modport master (
        output in_valid, in_data, in_parity, chk_en, out_ready,
        input  in_ready, out_valid, out_data, out_parity, out_err
    );
endinterface

// File: rtl/parity_stream_pipe.sv
// One-stage registered parity generator/checker on a valid/ready stream.
// Define PARITY_ERR_CNT_EN to add the saturating err_cnt output.
module parity_stream_pipe #(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b0,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    parity_stream_if.slave       strm,
    input  logic                 err_clr,
    output logic                 err_sticky
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]     err_cnt
`endif
);
    typedef logic [CNT_W-1:0] cnt_t;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_parity_q, out_parity_d;
    logic              out_err_q, out_err_d;
    logic              err_sticky_q, err_sticky_d;
    logic              in_ready_w;
    logic              accept_w;
    logic              par_w;
    logic              bad_beat_w;

    assign in_ready_w = !out_valid_q || strm.out_ready;
    assign accept_w   = strm.in_valid && in_ready_w;
    assign par_w      = ODD ? ~(^strm.in_data) : ^strm.in_data;
    // chk_en travels with the beat, so a mismatch only counts on an accepted beat.
    assign bad_beat_w = accept_w && strm.chk_en && (par_w != strm.in_parity);

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_parity_d = out_parity_q;
        out_err_d    = out_err_q;
        if (accept_w) begin
            out_valid_d  = 1'b1;
            out_data_d   = strm.in_data;
            out_parity_d = par_w;
            out_err_d    = strm.chk_en && (par_w != strm.in_parity);
        end else if (strm.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        err_sticky_d = err_sticky_q;
        if (bad_beat_w) begin
            err_sticky_d = 1'b1;
        end else if (err_clr) begin
            err_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_parity_q <= 1'b0;
            out_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_parity_q <= out_parity_d;
            out_err_q    <= out_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

`ifdef PARITY_ERR_CNT_EN
    cnt_t err_cnt_q, err_cnt_d;

    // A clear on the same edge as a bad beat restarts the count at one.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = bad_beat_w ? cnt_t'(1) : '0;
        end else if (bad_beat_w && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign strm.in_ready   = in_ready_w;
    assign strm.out_valid  = out_valid_q;
    assign strm.out_data   = out_data_q;
    assign strm.out_parity = out_parity_q;
    assign strm.out_err    = out_err_q;
    assign err_sticky      = err_sticky_q;
endmodule

// File: tb/tb_parity_stream_pipe.sv
// Bench for parity_stream_pipe: an even-parity instance with a scoreboard on its
// output stream plus directed checks, and an odd-parity instance for T3.
module tb_parity_stream_pipe;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              parity;
    logic              err;
  } beat_t;

  logic clk;
  logic rst_n;
  logic err_clr0;
  logic err_sticky0;
  logic err_clr1;
  logic err_sticky1;
`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt0;
  logic [7:0]       err_cnt1;
`endif

  int err_count;
  int chk_count;
  int pop_cnt;
  int pop_base;
  beat_t exp_q[$];

  parity_stream_if #(.DATA_W(DATA_W)) if0 ();
  parity_stream_if #(.DATA_W(DATA_W)) if1 ();

  parity_stream_pipe #(.DATA_W(DATA_W), .ODD(1'b0), .CNT_W(CNT_W)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .strm       (if0),
    .err_clr    (err_clr0),
    .err_sticky (err_sticky0)
`ifdef PARITY_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt0)
`endif
  );

  parity_stream_pipe #(.DATA_W(DATA_W), .ODD(1'b1), .CNT_W(8)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .strm       (if1),
    .err_clr    (err_clr1),
    .err_sticky (err_sticky1)
`ifdef PARITY_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt1)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_parity(input logic [DATA_W-1:0] d, input bit odd);
    int ones;
    ones = 0;
    for (int i = 0; i < DATA_W; i++) ones += int'(d[i]);
    return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_count++;
    assert (obs === exp) else begin
      err_count++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic drive0(input logic [DATA_W-1:0] d, input logic par, input logic chk);
    if0.in_valid  = 1'b1;
    if0.in_data   = d;
    if0.in_parity = par;
    if0.chk_en    = chk;
    @(posedge clk);
    #1;
    if0.in_valid = 1'b0;
  endtask

  task automatic drive1(input logic [DATA_W-1:0] d, input logic par);
    if1.in_valid  = 1'b1;
    if1.in_data   = d;
    if1.in_parity = par;
    if1.chk_en    = 1'b1;
    @(posedge clk);
    #1;
    if1.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // scoreboard on dut0: consume on output handshake, then record accepted input
  always @(negedge clk) begin
    beat_t got;
    beat_t exp;
    logic  p;
    if (rst_n) begin
      check("out_valid_model", 32'(if0.out_valid), 32'(exp_q.size() != 0));
      check("in_ready_model", 32'(if0.in_ready), 32'((exp_q.size() == 0) || if0.out_ready));
      if (if0.out_valid && if0.out_ready) begin
        got = '{if0.out_data, if0.out_parity, if0.out_err};
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(got), 32'hDEAD);
        end else begin
          exp = exp_q.pop_front();
          check("sb_beat", 32'(got), 32'(exp));
          pop_cnt++;
        end
      end
      if (if0.in_valid && if0.in_ready) begin
        p = ref_parity(if0.in_data, 1'b0);
        exp_q.push_back('{if0.in_data, p, if0.chk_en && (p != if0.in_parity)});
      end
    end
  end

  initial begin
    err_count = 0;
    chk_count = 0;
    pop_cnt   = 0;
    rst_n     = 1'b0;
    err_clr0  = 1'b0;
    err_clr1  = 1'b0;
    if0.in_valid = 1'b0; if0.in_data = '0; if0.in_parity = 1'b0; if0.chk_en = 1'b1;
    if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_data = '0; if1.in_parity = 1'b0; if1.chk_en = 1'b1;
    if1.out_ready = 1'b1;

    #2;
    check("rst_out_valid", 32'(if0.out_valid), 32'd0);
    check("rst_out_data", 32'(if0.out_data), 32'd0);
    check("rst_sticky", 32'(err_sticky0), 32'd0);
`ifdef PARITY_ERR_CNT_EN
    check("rst_err_cnt", 32'(err_cnt0), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // T1: even parity, clean beat
    drive0(8'hA5, 1'b0, 1'b1);
    check("t1_parity", 32'(if0.out_parity), 32'd0);
    check("t1_err", 32'(if0.out_err), 32'd0);
    check("t1_sticky", 32'(err_sticky0), 32'd0);

    // T2: mismatch, then same beat with checking disabled
    drive0(8'h07, 1'b0, 1'b1);
    check("t2_parity", 32'(if0.out_parity), 32'd1);
    check("t2_err", 32'(if0.out_err), 32'd1);
    check("t2_sticky", 32'(err_sticky0), 32'd1);
`ifdef PARITY_ERR_CNT_EN
    check("t2_cnt", 32'(err_cnt0), 32'd1);
`endif
    drive0(8'h07, 1'b0, 1'b0);
    check("t2_nochk_err", 32'(if0.out_err), 32'd0);
    check("t2_nochk_sticky", 32'(err_sticky0), 32'd1);
`ifdef PARITY_ERR_CNT_EN
    check("t2_nochk_cnt", 32'(err_cnt0), 32'd1);
`endif
    err_clr0 = 1'b1;
    idle(1);
    err_clr0 = 1'b0;
    check("clr_sticky", 32'(err_sticky0), 32'd0);
`ifdef PARITY_ERR_CNT_EN
    check("clr_cnt", 32'(err_cnt0), 32'd0);
`endif

    // T3: odd parity instance
    drive1(8'h00, 1'b1);
    check("t3_parity", 32'(if1.out_parity), 32'd1);
    check("t3_err_ok", 32'(if1.out_err), 32'd0);
    drive1(8'h00, 1'b0);
    check("t3_err_bad", 32'(if1.out_err), 32'd1);
    check("t3_sticky", 32'(err_sticky1), 32'd1);

    // T4: backpressure then full-rate streaming
    idle(2);
    if0.out_ready = 1'b0;
    pop_base = pop_cnt;
    drive0(8'h3C, 1'b0, 1'b1);
    if0.in_valid = 1'b1;
    if0.in_data  = 8'h11;
    for (int i = 0; i < 5; i++) begin
      check("t4_in_ready", 32'(if0.in_ready), 32'd0);
      check("t4_hold_data", 32'(if0.out_data), 32'h3C);
      check("t4_hold_valid", 32'(if0.out_valid), 32'd1);
      idle(1);
    end
    if0.out_ready = 1'b1;
    idle(1);
    for (int i = 0; i < 8; i++) begin
      if0.in_data   = DATA_W'($urandom_range(0, 255));
      if0.in_parity = 1'($urandom_range(0, 1));
      if0.chk_en    = 1'($urandom_range(0, 1));
      idle(1);
    end
    if0.in_valid = 1'b0;
    if0.chk_en   = 1'b1;
    idle(2);
    check("t4_beats_out", 32'(pop_cnt - pop_base), 32'd10);
    err_clr0 = 1'b1;
    idle(1);
    err_clr0 = 1'b0;

    // T5: saturation and same-edge clear with a bad beat
    for (int i = 0; i < 5; i++) drive0(8'h07, 1'b0, 1'b1);
    check("t5_sticky", 32'(err_sticky0), 32'd1);
`ifdef PARITY_ERR_CNT_EN
    check("t5_sat", 32'(err_cnt0), 32'd3);
`endif
    err_clr0 = 1'b1;
    drive0(8'h07, 1'b0, 1'b1);
    err_clr0 = 1'b0;
    check("t5_clr_bad_sticky", 32'(err_sticky0), 32'd1);
`ifdef PARITY_ERR_CNT_EN
    check("t5_clr_bad_cnt", 32'(err_cnt0), 32'd1);
`endif

    // T6: asynchronous reset while stalled
    idle(1);
    if0.out_ready = 1'b0;
    drive0(8'h55, 1'b1, 1'b1);
    check("t6_pre_valid", 32'(if0.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_valid", 32'(if0.out_valid), 32'd0);
    check("t6_data", 32'(if0.out_data), 32'd0);
    check("t6_parity", 32'(if0.out_parity), 32'd0);
    check("t6_err", 32'(if0.out_err), 32'd0);
    check("t6_sticky", 32'(err_sticky0), 32'd0);
`ifdef PARITY_ERR_CNT_EN
    check("t6_cnt", 32'(err_cnt0), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    if0.out_ready = 1'b1;
    idle(1);
    drive0(8'hFF, 1'b0, 1'b1);
    check("t6_ff_parity", 32'(if0.out_parity), 32'd0);
    check("t6_ff_err", 32'(if0.out_err), 32'd0);
    check("t6_ff_data", 32'(if0.out_data), 32'hFF);
    idle(2);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_count, chk_count);
    $finish;
  end
endmodule
